// File: rtl/reorder_queue_pkg.sv
// Shared types and width helpers for the completion reorder queue.
// Used by both the input (write) side and the in-order drain side.
package reorder_queue_pkg;

  localparam int RQ_DW_COUNT_WIDTH = 8;
  localparam int RQ_MAPPED_WIDTH   = 6;

  // Ceiling log2 with a minimum result of 1.
  function automatic int clog2s(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) res++;
    return (res == 0) ? 1 : res;
  endfunction

  function automatic int pci_data_word(input int data_width);
    return data_width / 32;
  endfunction

  function automatic int pci_data_count_width(input int data_width);
    return clog2s(data_width / 32 + 1);
  endfunction

  typedef struct packed {
    logic                         valid;
    logic [RQ_DW_COUNT_WIDTH-1:0] expected;
    logic [RQ_DW_COUNT_WIDTH-1:0] received;
    logic [RQ_MAPPED_WIDTH-1:0]   mapped;
    logic                         last;
    logic                         err;
  } tag_rec_t;

  function automatic logic words_lte1(input logic [RQ_DW_COUNT_WIDTH-1:0] words,
                                      input int data_word);
    return int'(words) <= data_word;
  endfunction

  function automatic logic words_lte2(input logic [RQ_DW_COUNT_WIDTH-1:0] words,
                                      input int data_word);
    return int'(words) <= 2 * data_word;
  endfunction

endpackage

// File: rtl/reorder_queue_input_if.sv
// Bus bundle between the completion source / drain logic and reorder_queue_input.
// The queue is the slave; the surrounding logic is the master.
interface reorder_queue_input_if
  import reorder_queue_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH     = 128,
  parameter int C_TAG_WIDTH          = 5,
  parameter int C_TAG_DW_COUNT_WIDTH = 8,
  parameter int C_DATA_ADDR_WIDTH    = 10
);

  localparam int C_PCI_DATA_WORD        = pci_data_word(C_PCI_DATA_WIDTH);
  localparam int C_PCI_DATA_COUNT_WIDTH = pci_data_count_width(C_PCI_DATA_WIDTH);
  localparam int C_NUM_TAGS             = 2 ** C_TAG_WIDTH;

  logic                              ALLOC_VALID;
  logic [C_TAG_WIDTH-1:0]            ALLOC_TAG;
  logic [C_TAG_DW_COUNT_WIDTH-1:0]   ALLOC_WORDS;
  logic [5:0]                        ALLOC_MAPPED;
  logic                              ALLOC_LAST;

  logic                              CPL_VALID;
  logic [C_TAG_WIDTH-1:0]            CPL_TAG;
  logic [C_PCI_DATA_WIDTH-1:0]       CPL_DATA;
  logic [C_PCI_DATA_COUNT_WIDTH-1:0] CPL_DATA_EN;
  logic                              CPL_ERR;

  logic                              WR_EN;
  logic [C_DATA_ADDR_WIDTH-1:0]      WR_ADDR;
  logic [C_PCI_DATA_WIDTH-1:0]       WR_DATA;
  logic [C_PCI_DATA_WORD-1:0]        WR_DW_EN;

  logic [C_NUM_TAGS-1:0]             TAG_FINISHED;
  logic [C_NUM_TAGS-1:0]             TAG_CLEAR;
  logic [C_TAG_WIDTH-1:0]            TAG;
  logic [5:0]                        TAG_MAPPED;
  logic [C_TAG_DW_COUNT_WIDTH-1:0]   PKT_WORDS;
  logic                              PKT_WORDS_LTE1;
  logic                              PKT_WORDS_LTE2;
  logic                              PKT_DONE;
  logic                              PKT_ERR;
  logic                              UNEXP_CPL;

  modport master (
    output ALLOC_VALID, ALLOC_TAG, ALLOC_WORDS, ALLOC_MAPPED, ALLOC_LAST,
    output CPL_VALID, CPL_TAG, CPL_DATA, CPL_DATA_EN, CPL_ERR,
    output TAG_CLEAR, TAG,
    input  WR_EN, WR_ADDR, WR_DATA, WR_DW_EN,
    input  TAG_FINISHED, TAG_MAPPED, PKT_WORDS, PKT_WORDS_LTE1, PKT_WORDS_LTE2,
    input  PKT_DONE, PKT_ERR, UNEXP_CPL
  );

  modport slave (
    input  ALLOC_VALID, ALLOC_TAG, ALLOC_WORDS, ALLOC_MAPPED, ALLOC_LAST,
    input  CPL_VALID, CPL_TAG, CPL_DATA, CPL_DATA_EN, CPL_ERR,
    input  TAG_CLEAR, TAG,
    output WR_EN, WR_ADDR, WR_DATA, WR_DW_EN,
    output TAG_FINISHED, TAG_MAPPED, PKT_WORDS, PKT_WORDS_LTE1, PKT_WORDS_LTE2,
    output PKT_DONE, PKT_ERR, UNEXP_CPL
  );

endinterface

// File: rtl/reorder_queue_input_tag_table.sv
// Per-tag record array with finished bitmap: alloc/update/clear write port,
// combinational lookup for the completion tag, registered lookup for the drain tag.
module reorder_tag_table
  import reorder_queue_pkg::*;
#(
  parameter  int C_TAG_WIDTH     = 5,
  parameter  int C_PCI_DATA_WORD = 4,
  localparam int C_NUM_TAGS      = 2 ** C_TAG_WIDTH
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         alloc_en_i,
  input  logic [C_TAG_WIDTH-1:0]       alloc_tag_i,
  input  logic [RQ_DW_COUNT_WIDTH-1:0] alloc_words_i,
  input  logic [RQ_MAPPED_WIDTH-1:0]   alloc_mapped_i,
  input  logic                         alloc_last_i,
  input  logic                         upd_en_i,
  input  logic [C_TAG_WIDTH-1:0]       upd_tag_i,
  input  logic [RQ_DW_COUNT_WIDTH-1:0] upd_received_i,
  input  logic                         upd_err_i,
  input  logic [C_NUM_TAGS-1:0]        clear_i,
  input  logic [C_TAG_WIDTH-1:0]       cpl_tag_i,
  output logic                         cpl_valid_o,
  output logic [RQ_DW_COUNT_WIDTH-1:0] cpl_expected_o,
  output logic [RQ_DW_COUNT_WIDTH-1:0] cpl_received_o,
  input  logic [C_TAG_WIDTH-1:0]       qry_tag_i,
  output logic [RQ_MAPPED_WIDTH-1:0]   qry_mapped_o,
  output logic [RQ_DW_COUNT_WIDTH-1:0] qry_words_o,
  output logic                         qry_lte1_o,
  output logic                         qry_lte2_o,
  output logic                         qry_last_o,
  output logic                         qry_err_o,
  output logic [C_NUM_TAGS-1:0]        finished_o
);

  tag_rec_t              rec_q [C_NUM_TAGS];
  logic [C_NUM_TAGS-1:0] finished_q;
  tag_rec_t              qry_q;
  logic                  qry_lte1_q;
  logic                  qry_lte2_q;

  // Same-cycle updates land at the edge, so a beat on the next cycle reads
  // the advanced offset here without a bubble.
  assign cpl_valid_o    = rec_q[cpl_tag_i].valid;
  assign cpl_expected_o = rec_q[cpl_tag_i].expected;
  assign cpl_received_o = rec_q[cpl_tag_i].received;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the records live in flops (valid must clear on reset), so the
      // whole array is reset here; this is not a RAM.
      for (int t = 0; t < C_NUM_TAGS; t++) rec_q[t] <= '0;
      finished_q <= '0;
      qry_q      <= '0;
      qry_lte1_q <= 1'b0;
      qry_lte2_q <= 1'b0;
    end else begin
      for (int t = 0; t < C_NUM_TAGS; t++) begin
        if (alloc_en_i && alloc_tag_i == C_TAG_WIDTH'(t)) begin
          rec_q[t] <= '{valid: 1'b1, expected: alloc_words_i, received: '0,
                        mapped: alloc_mapped_i, last: alloc_last_i, err: 1'b0};
          finished_q[t] <= 1'b0;
        end else if (clear_i[t]) begin
          rec_q[t].valid    <= 1'b0;
          rec_q[t].received <= '0;
          rec_q[t].err      <= 1'b0;
          finished_q[t]     <= 1'b0;
        end else begin
          if (upd_en_i && upd_tag_i == C_TAG_WIDTH'(t)) begin
            rec_q[t].received <= upd_received_i;
            rec_q[t].err      <= rec_q[t].err | upd_err_i;
          end
          // Evaluated on the registered record, one cycle after its last write.
          if (rec_q[t].valid &&
              (rec_q[t].received == rec_q[t].expected || rec_q[t].err))
            finished_q[t] <= 1'b1;
        end
      end
      qry_q      <= rec_q[qry_tag_i];
      qry_lte1_q <= words_lte1(rec_q[qry_tag_i].received, C_PCI_DATA_WORD);
      qry_lte2_q <= words_lte2(rec_q[qry_tag_i].received, C_PCI_DATA_WORD);
    end
  end

  assign qry_mapped_o = qry_q.mapped;
  assign qry_words_o  = qry_q.received;
  assign qry_last_o   = qry_q.last;
  assign qry_err_o    = qry_q.err;
  assign qry_lte1_o   = qry_lte1_q;
  assign qry_lte2_o   = qry_lte2_q;
  assign finished_o   = finished_q;

endmodule

// File: rtl/reorder_queue_input.sv
// Write side of the completion reorder queue: lands payload beats in the packet
// RAM at {tag, beat} addresses and tracks per-tag completion for the drain side.
module reorder_queue_input
  import reorder_queue_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH         = 128,
  parameter int C_TAG_WIDTH              = 5,
  parameter int C_TAG_DW_COUNT_WIDTH     = RQ_DW_COUNT_WIDTH,
  parameter int C_DATA_ADDR_STRIDE_WIDTH = 5,
  parameter int C_DATA_ADDR_WIDTH        = 10
) (
  input logic                  CLK,
  input logic                  RST,
  reorder_queue_input_if.slave rq
);

  localparam int C_PCI_DATA_WORD        = pci_data_word(C_PCI_DATA_WIDTH);
  localparam int C_PCI_DATA_COUNT_WIDTH = pci_data_count_width(C_PCI_DATA_WIDTH);
  localparam int CW                     = C_TAG_DW_COUNT_WIDTH;

  logic                              cpl_valid;
  logic [CW-1:0]                     cpl_expected;
  logic [CW-1:0]                     cpl_received;
  logic [CW-1:0]                     room;
  logic [CW-1:0]                     upd_received;
  logic [C_PCI_DATA_COUNT_WIDTH-1:0] eff_en;
  logic                              overflow;
  logic                              accept;
  logic                              upd_err;

  logic                              wr_en_d,    wr_en_q;
  logic [C_DATA_ADDR_WIDTH-1:0]      wr_addr_d,  wr_addr_q;
  logic [C_PCI_DATA_WIDTH-1:0]       wr_data_d,  wr_data_q;
  logic [C_PCI_DATA_WORD-1:0]        wr_dw_en_d, wr_dw_en_q;
  logic                              unexp_d,    unexp_q;

  // Received never exceeds expected, so the remaining room cannot underflow;
  // an oversized beat is trimmed to exactly that room.
  always_comb begin
    // NOTE: every signal below is assigned on every path, so no latch is inferred.
    room         = cpl_expected - cpl_received;
    accept       = rq.CPL_VALID && cpl_valid;
    overflow     = CW'(rq.CPL_DATA_EN) > room;
    eff_en       = overflow ? room[C_PCI_DATA_COUNT_WIDTH-1:0] : rq.CPL_DATA_EN;
    upd_received = cpl_received + CW'(eff_en);
    upd_err      = rq.CPL_ERR || overflow;
    wr_en_d      = accept && (eff_en != '0);
    unexp_d      = rq.CPL_VALID && (!cpl_valid || overflow);
    wr_addr_d    = {rq.CPL_TAG,
                    cpl_received[C_DATA_ADDR_STRIDE_WIDTH+C_PCI_DATA_COUNT_WIDTH-2 :
                                 C_PCI_DATA_COUNT_WIDTH-1]};
    wr_data_d    = rq.CPL_DATA;
    for (int i = 0; i < C_PCI_DATA_WORD; i++) wr_dw_en_d[i] = (i < int'(eff_en));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_dw_en_q <= '0;
      unexp_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_dw_en_q <= wr_dw_en_d;
      unexp_q    <= unexp_d;
    end
  end

  reorder_tag_table #(
    .C_TAG_WIDTH     (C_TAG_WIDTH),
    .C_PCI_DATA_WORD (C_PCI_DATA_WORD)
  ) u_tag_table (
    .CLK            (CLK),
    .RST            (RST),
    .alloc_en_i     (rq.ALLOC_VALID),
    .alloc_tag_i    (rq.ALLOC_TAG),
    .alloc_words_i  (rq.ALLOC_WORDS),
    .alloc_mapped_i (rq.ALLOC_MAPPED),
    .alloc_last_i   (rq.ALLOC_LAST),
    .upd_en_i       (accept),
    .upd_tag_i      (rq.CPL_TAG),
    .upd_received_i (upd_received),
    .upd_err_i      (upd_err),
    .clear_i        (rq.TAG_CLEAR),
    .cpl_tag_i      (rq.CPL_TAG),
    .cpl_valid_o    (cpl_valid),
    .cpl_expected_o (cpl_expected),
    .cpl_received_o (cpl_received),
    .qry_tag_i      (rq.TAG),
    .qry_mapped_o   (rq.TAG_MAPPED),
    .qry_words_o    (rq.PKT_WORDS),
    .qry_lte1_o     (rq.PKT_WORDS_LTE1),
    .qry_lte2_o     (rq.PKT_WORDS_LTE2),
    .qry_last_o     (rq.PKT_DONE),
    .qry_err_o      (rq.PKT_ERR),
    .finished_o     (rq.TAG_FINISHED)
  );

  assign rq.WR_EN     = wr_en_q;
  assign rq.WR_ADDR   = wr_addr_q;
  assign rq.WR_DATA   = wr_data_q;
  assign rq.WR_DW_EN  = wr_dw_en_q;
  assign rq.UNEXP_CPL = unexp_q;

endmodule

// File: tb/tb_reorder_queue_input.sv
// Directed bench for reorder_queue_input: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares them; status outputs checked inline.
module tb_reorder_queue_input;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_queue_input_if #(
    .C_PCI_DATA_WIDTH(128), .C_TAG_WIDTH(5),
    .C_TAG_DW_COUNT_WIDTH(8), .C_DATA_ADDR_WIDTH(10)
  ) rq ();

  reorder_queue_input #(
    .C_PCI_DATA_WIDTH(128), .C_TAG_WIDTH(5), .C_TAG_DW_COUNT_WIDTH(8),
    .C_DATA_ADDR_STRIDE_WIDTH(5), .C_DATA_ADDR_WIDTH(10)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .rq  (rq)
  );

  typedef struct {
    logic [9:0]   addr;
    logic [127:0] data;
    logic [3:0]   mask;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  unexp_seen = 0;
  int  unexp_exp = 0;
  int  beat_no = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int tag, input int k);
    return {8'(tag), 8'(k), 16'hBEEF, 32'hC0DE0000 | 32'(k),
            32'h12345678 ^ 32'(tag), 32'hA5A5A5A5};
  endfunction

  // Write-port monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (rq.WR_EN) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr %0d mask %b, expected no write",
                   rq.WR_ADDR, rq.WR_DW_EN);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 128'(rq.WR_ADDR), 128'(e.addr));
          check("wr_data", rq.WR_DATA, e.data);
          check("wr_dw_en", 128'(rq.WR_DW_EN), 128'(e.mask));
        end
      end
      if (rq.UNEXP_CPL) unexp_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rq.ALLOC_VALID = 1'b0;
    rq.CPL_VALID   = 1'b0;
    rq.CPL_ERR     = 1'b0;
    rq.TAG_CLEAR   = '0;
  endtask

  task automatic idle();
    step();
    clr();
  endtask

  task automatic alloc(input int tag, input int words, input int mapped, input bit last,
                       input logic [31:0] clear_mask);
    step();
    clr();
    rq.ALLOC_VALID  = 1'b1;
    rq.ALLOC_TAG    = 5'(tag);
    rq.ALLOC_WORDS  = 8'(words);
    rq.ALLOC_MAPPED = 6'(mapped);
    rq.ALLOC_LAST   = last;
    rq.TAG_CLEAR    = clear_mask;
  endtask

  task automatic clear_tags(input logic [31:0] mask);
    step();
    clr();
    rq.TAG_CLEAR = mask;
  endtask

  task automatic beat(input int tag, input int en, input bit err,
                      input bit wr, input int addr, input logic [3:0] mask);
    step();
    clr();
    rq.CPL_VALID   = 1'b1;
    rq.CPL_TAG     = 5'(tag);
    rq.CPL_DATA    = pat(tag, beat_no);
    rq.CPL_DATA_EN = 3'(en);
    rq.CPL_ERR     = err;
    if (wr) exp_q.push_back('{addr: 10'(addr), data: pat(tag, beat_no), mask: mask});
    beat_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rq.ALLOC_TAG = '0; rq.ALLOC_WORDS = '0; rq.ALLOC_MAPPED = '0; rq.ALLOC_LAST = 1'b0;
    rq.CPL_TAG = '0; rq.CPL_DATA = '0; rq.CPL_DATA_EN = '0; rq.TAG = '0;
    clr();
    repeat (3) step();
    check("rst_finished", 128'(rq.TAG_FINISHED), 128'd0);
    check("rst_wr_en", 128'(rq.WR_EN), 128'd0);
    check("rst_unexp", 128'(rq.UNEXP_CPL), 128'd0);
    check("rst_pkt_words", 128'(rq.PKT_WORDS), 128'd0);
    check("rst_lte1", 128'(rq.PKT_WORDS_LTE1), 128'd0);
    rst = 1'b0;
    step();

    // Basic packet: tag 3, 10 DWs as 4+4+2.
    alloc(3, 10, 6'h15, 1'b1, '0);
    beat(3, 4, 1'b0, 1'b1, 96, 4'b1111);
    beat(3, 4, 1'b0, 1'b1, 97, 4'b1111);
    beat(3, 2, 1'b0, 1'b1, 98, 4'b0011);
    rq.TAG = 5'd3;
    idle();
    check("basic_fin_n1", 128'(rq.TAG_FINISHED[3]), 128'd0);
    step();
    check("basic_fin_n2", 128'(rq.TAG_FINISHED[3]), 128'd1);
    step();
    check("basic_pkt_words", 128'(rq.PKT_WORDS), 128'd10);
    check("basic_lte1", 128'(rq.PKT_WORDS_LTE1), 128'd0);
    check("basic_lte2", 128'(rq.PKT_WORDS_LTE2), 128'd0);
    check("basic_done", 128'(rq.PKT_DONE), 128'd1);
    check("basic_mapped", 128'(rq.TAG_MAPPED), 128'h15);
    check("basic_err", 128'(rq.PKT_ERR), 128'd0);
    clear_tags(32'h8);
    idle();
    check("clear_fin", 128'(rq.TAG_FINISHED), 128'd0);

    // Out of order: tag 1 completes before tag 0.
    alloc(0, 4, 1, 1'b0, '0);
    alloc(1, 4, 2, 1'b0, '0);
    beat(1, 4, 1'b0, 1'b1, 32, 4'b1111);
    beat(0, 4, 1'b0, 1'b1, 0, 4'b1111);
    idle();
    check("ooo_first", 128'(rq.TAG_FINISHED), 128'h2);
    step();
    check("ooo_both", 128'(rq.TAG_FINISHED), 128'h3);
    clear_tags(32'h3);

    // Back-to-back: tag 7, four full beats on consecutive cycles.
    alloc(7, 16, 7, 1'b1, '0);
    for (int k = 0; k < 4; k++) beat(7, 4, 1'b0, 1'b1, 224 + k, 4'b1111);
    idle();
    step();
    check("b2b_fin", 128'(rq.TAG_FINISHED), 128'h80);
    check("b2b_unexp", 128'(unexp_seen), 128'(unexp_exp));

    // Error completion finishes a partially received tag.
    alloc(5, 8, 9, 1'b0, '0);
    beat(5, 4, 1'b1, 1'b1, 160, 4'b1111);
    rq.TAG = 5'd5;
    idle();
    step();
    check("err_fin", 128'(rq.TAG_FINISHED[5]), 128'd1);
    check("err_pkt_err", 128'(rq.PKT_ERR), 128'd1);
    check("err_pkt_words", 128'(rq.PKT_WORDS), 128'd4);
    check("err_lte1", 128'(rq.PKT_WORDS_LTE1), 128'd1);
    check("err_lte2", 128'(rq.PKT_WORDS_LTE2), 128'd1);

    // Beat for unallocated tag 9 is dropped.
    beat(9, 4, 1'b0, 1'b0, 0, 4'b0000);
    unexp_exp++;
    idle();
    step();
    check("unalloc_unexp", 128'(unexp_seen), 128'(unexp_exp));
    check("unalloc_fin", 128'(rq.TAG_FINISHED[9]), 128'd0);

    // Overflow: 6 DWs into a 4-DW tag; only the first 4 are written.
    alloc(4, 4, 3, 1'b0, '0);
    beat(4, 4, 1'b0, 1'b1, 128, 4'b1111);
    beat(4, 2, 1'b0, 1'b0, 0, 4'b0000);
    unexp_exp++;
    rq.TAG = 5'd4;
    idle();
    step();
    check("ovf_unexp", 128'(unexp_seen), 128'(unexp_exp));
    check("ovf_err", 128'(rq.PKT_ERR), 128'd1);
    check("ovf_words", 128'(rq.PKT_WORDS), 128'd4);
    check("ovf_fin", 128'(rq.TAG_FINISHED[4]), 128'd1);

    // Alloc and clear of tag 2 in one cycle: alloc wins.
    alloc(2, 4, 4, 1'b0, '0);
    beat(2, 4, 1'b0, 1'b1, 64, 4'b1111);
    idle();
    step();
    check("coll_pre_fin", 128'(rq.TAG_FINISHED[2]), 128'd1);
    alloc(2, 4, 4, 1'b0, 32'h4);
    idle();
    check("coll_fin_n1", 128'(rq.TAG_FINISHED[2]), 128'd0);
    step();
    check("coll_fin_n2", 128'(rq.TAG_FINISHED[2]), 128'd0);
    beat(2, 4, 1'b0, 1'b1, 64, 4'b1111);
    idle();
    step();
    check("coll_valid_fin", 128'(rq.TAG_FINISHED[2]), 128'd1);
    check("coll_unexp", 128'(unexp_seen), 128'(unexp_exp));

    // Reset mid-packet discards all state.
    alloc(10, 8, 6'h2A, 1'b1, '0);
    beat(10, 4, 1'b0, 1'b1, 320, 4'b1111);
    rq.TAG = 5'd10;
    idle();
    step();
    check("pre_rst_words", 128'(rq.PKT_WORDS), 128'd4);
    rst = 1'b1;
    #2;
    check("rst_mid_finished", 128'(rq.TAG_FINISHED), 128'd0);
    check("rst_mid_words", 128'(rq.PKT_WORDS), 128'd0);
    check("rst_mid_mapped", 128'(rq.TAG_MAPPED), 128'd0);
    check("rst_mid_done", 128'(rq.PKT_DONE), 128'd0);
    check("rst_mid_wr_en", 128'(rq.WR_EN), 128'd0);
    check("rst_mid_unexp", 128'(rq.UNEXP_CPL), 128'd0);
    repeat (2) step();
    rst = 1'b0;
    beat(10, 4, 1'b0, 1'b0, 0, 4'b0000);
    unexp_exp++;
    idle();
    step();
    check("post_rst_unexp", 128'(unexp_seen), 128'(unexp_exp));
    check("post_rst_finished", 128'(rq.TAG_FINISHED), 128'd0);

    repeat (3) step();
    check("writes_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
